// File: rtl/decompressor_ring.sv
// rtl/decompressor_ring.sv - unpacks LSB-first densely packed values from 16-bit words, one value per handshake.
// Optional feature macro: DECOMP_UNSIGNED_MODE_EN (adds is_unsigned, zero-extends output when set).
module decompressor_ring #(
  parameter int INPUT_BITWIDTH = 16,
  parameter int MAXBITWIDTH    = 16,
  parameter int BUF_SIZE       = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [4:0]                bitwidth_d,
  input  logic [31:0]               num_of_values,
`ifdef DECOMP_UNSIGNED_MODE_EN
  input  logic                      is_unsigned,
`endif
  input  logic                      rcv_valid,
  input  logic [INPUT_BITWIDTH-1:0] rcv_data,
  output logic                      rcv_ready,
  output logic                      trm_valid,
  output logic [MAXBITWIDTH-1:0]    trm_data,
  output logic                      trm_last,
  input  logic                      trm_ready,
  output logic                      busy,
  output logic                      cfg_err
);

  localparam int FW = $clog2(BUF_SIZE + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state;
  logic [BUF_SIZE-1:0]   r_buf;
  logic [FW-1:0]         r_fill;
  logic [4:0]            r_bw;
  logic [31:0]           r_n;
  logic [32:0]           r_words_total;
  logic [32:0]           r_words_rx;
  logic [31:0]           r_vals_tx;
  logic                  r_cfg_err;
  logic                  r_unsigned;

  logic [36:0]           w_bits_rnd;
  logic [32:0]           w_words_total;
  logic                  w_cfg_bad;
  logic                  w_push;
  logic                  w_pop;
  logic [FW-1:0]         w_base;
  logic [FW-1:0]         w_fill_next;
  logic [BUF_SIZE-1:0]   w_buf_next;
  logic [MAXBITWIDTH-1:0] w_mask;
  logic [MAXBITWIDTH-1:0] w_raw;
  logic                  w_sign;

  // Product is 37 bits wide so a full 32-bit count at bitwidth 31 cannot wrap.
  assign w_bits_rnd    = ({5'd0, num_of_values} * {32'd0, bitwidth_d}) + 37'd15;
  assign w_words_total = 33'(w_bits_rnd >> 4);
  assign w_cfg_bad     = (bitwidth_d == 5'd0) || (bitwidth_d > 5'd16) || (num_of_values == 32'd0);

  assign busy      = (r_state == S_RUN);
  assign cfg_err   = r_cfg_err;
  assign rcv_ready = busy && (r_fill <= FW'(INPUT_BITWIDTH)) && (r_words_rx < r_words_total);
  assign trm_valid = busy && (r_fill >= FW'(r_bw));
  assign trm_last  = trm_valid && (r_vals_tx == (r_n - 32'd1));

  assign w_push = rcv_valid && rcv_ready;
  assign w_pop  = trm_valid && trm_ready;

  assign w_mask = {MAXBITWIDTH{1'b1}} >> (MAXBITWIDTH - int'(r_bw));
  assign w_raw  = r_buf[MAXBITWIDTH-1:0] & w_mask;
  assign w_sign = r_buf[r_bw - 5'd1] && !r_unsigned;

  always_comb begin
    trm_data = '0;
    if (busy) begin
      trm_data = w_sign ? (w_raw | ~w_mask) : w_raw;
    end
  end

  // Bits at or above r_fill are always zero, so a new word can be OR-ed in place.
  assign w_base      = w_pop ? (r_fill - FW'(r_bw)) : r_fill;
  assign w_fill_next = r_fill + (w_push ? FW'(INPUT_BITWIDTH) : FW'(0)) - (w_pop ? FW'(r_bw) : FW'(0));
  assign w_buf_next  = (w_pop ? (r_buf >> r_bw) : r_buf) |
                       (w_push ? ({{(BUF_SIZE-INPUT_BITWIDTH){1'b0}}, rcv_data} << w_base) : '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_buf         <= '0;
      r_fill        <= '0;
      r_bw          <= '0;
      r_n           <= '0;
      r_words_total <= '0;
      r_words_rx    <= '0;
      r_vals_tx     <= '0;
      r_cfg_err     <= 1'b0;
      r_unsigned    <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bw          <= bitwidth_d;
            r_n           <= num_of_values;
            r_words_total <= w_words_total;
`ifdef DECOMP_UNSIGNED_MODE_EN
            r_unsigned    <= is_unsigned;
`else
            r_unsigned    <= 1'b0;
`endif
            r_buf         <= '0;
            r_fill        <= '0;
            r_words_rx    <= '0;
            r_vals_tx     <= '0;
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_pop && trm_last) begin
            r_state <= S_IDLE;
            r_fill  <= '0;
            r_buf   <= '0;
          end else begin
            r_fill <= w_fill_next;
            r_buf  <= w_buf_next;
          end
          if (w_push) r_words_rx <= r_words_rx + 33'd1;
          if (w_pop)  r_vals_tx  <= r_vals_tx + 32'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decompressor_ring.sv
// tb/tb_decompressor_ring.sv - directed and gapped-stream bench for decompressor_ring with a bit-level value model.
module tb_decompressor_ring;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  bitwidth_d = '0;
  logic [31:0] num_of_values = '0;
  logic        rcv_valid = 1'b0;
  logic [15:0] rcv_data = '0;
  logic        rcv_ready;
  logic        trm_valid;
  logic [15:0] trm_data;
  logic        trm_last;
  logic        trm_ready = 1'b0;
  logic        busy;
  logic        cfg_err;

  int total = 0;
  int bad = 0;
  int widx = 0;
  int cyc = 0;

  logic [15:0] tb_words[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always #5 clk = ~clk;

  decompressor_ring dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .bitwidth_d(bitwidth_d),
    .num_of_values(num_of_values),
`ifdef DECOMP_UNSIGNED_MODE_EN
    .is_unsigned(1'b0),
`endif
    .rcv_valid(rcv_valid),
    .rcv_data(rcv_data),
    .rcv_ready(rcv_ready),
    .trm_valid(trm_valid),
    .trm_data(trm_data),
    .trm_last(trm_last),
    .trm_ready(trm_ready),
    .busy(busy),
    .cfg_err(cfg_err)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endfunction

  // Value i occupies stream bits [i*bw, i*bw+bw); bit p lives in word p/16, position p%16.
  task automatic build_exp(input int bw, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      int v;
      v = 0;
      for (int j = 0; j < bw; j++) begin
        int p;
        p = i * bw + j;
        if (tb_words[p / 16][p % 16]) v = v | (1 << j);
      end
      if (v >= (1 << (bw - 1))) v = v - (1 << bw);
      exp_q.push_back(v[15:0]);
    end
  endtask

  // One compare process: every cycle a value is presented it must equal the model head.
  always @(negedge clk) begin
    if (rstn && trm_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", {31'd0, trm_valid}, 32'd0);
      end else begin
        chk("trm_data", {16'd0, trm_data}, {16'd0, exp_q[0]});
        chk("trm_last", {31'd0, trm_last}, {31'd0, exp_q.size() == 1});
        if (prev_stall) begin
          chk("stable_data", {16'd0, trm_data}, {16'd0, prev_data});
          chk("stable_last", {31'd0, trm_last}, {31'd0, prev_last});
        end
        if (trm_ready) begin
          got_q.push_back(trm_data);
          void'(exp_q.pop_front());
        end
      end
    end
    prev_stall <= rstn && trm_valid && !trm_ready;
    prev_data  <= trm_data;
    prev_last  <= trm_last;
  end

  task automatic start_layer(input int bw, input int n);
    bitwidth_d    = bw[4:0];
    num_of_values = 32'(n);
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive(input int vgap, input int rgap);
    rcv_valid = (widx < tb_words.size()) && (int'($urandom_range(0, 99)) >= vgap);
    rcv_data  = (widx < tb_words.size()) ? tb_words[widx] : 16'h0;
    trm_ready = (int'($urandom_range(0, 99)) >= rgap);
  endtask

  task automatic pump(input int vgap, input int rgap, input int budget);
    cyc = 0;
    drive(vgap, rgap);
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      if (widx >= tb_words.size()) chk("rcv_ready_done", {31'd0, rcv_ready}, 32'd0);
      if (rcv_valid && rcv_ready) widx++;
      @(posedge clk); #1;
      drive(vgap, rgap);
      cyc++;
    end
    chk("drained", 32'(exp_q.size()), 32'd0);
    rcv_valid = 1'b0;
    trm_ready = 1'b0;
  endtask

  task automatic end_checks();
    @(negedge clk);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_valid", {31'd0, trm_valid}, 32'd0);
    chk("end_rcv_ready", {31'd0, rcv_ready}, 32'd0);
    chk("words_used", 32'(widx), 32'(tb_words.size()));
    @(posedge clk); #1;
  endtask

  task automatic run_layer(input int bw, input int n, input int vgap, input int rgap, input int budget);
    build_exp(bw, n);
    got_q.delete();
    widx = 0;
    start_layer(bw, n);
    pump(vgap, rgap, budget);
    end_checks();
  endtask

  task automatic random_words(input int bw, input int n);
    tb_words.delete();
    for (int i = 0; i < (n * bw + 15) / 16; i++) tb_words.push_back(16'($urandom));
  endtask

  task automatic cfg_case(input int bw, input int n, input string name);
    start_layer(bw, n);
    @(negedge clk);
    chk({name, "_pulse"}, {31'd0, cfg_err}, 32'd1);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_rcv_ready"}, {31'd0, rcv_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_clear"}, {31'd0, cfg_err}, 32'd0);
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_got(input string name, input logic [15:0] lit[$]);
    chk({name, "_count"}, 32'(got_q.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size(); i++)
      chk(name, {16'd0, (i < got_q.size()) ? got_q[i] : 16'hxxxx}, {16'd0, lit[i]});
  endtask

  task automatic check_model(input string name, input logic [15:0] lit[$]);
    for (int i = 0; i < lit.size(); i++)
      chk(name, {16'd0, (i < exp_q.size()) ? exp_q[i] : 16'hxxxx}, {16'd0, lit[i]});
  endtask

  logic [15:0] lit16[$];
  logic [15:0] lit4[$];
  logic [15:0] lit5[$];
  int          widths[$];

  initial begin
    lit16 = '{16'h8001, 16'h7FFF, 16'h0005};
    lit4  = '{16'hFFFF, 16'h0003, 16'h0005, 16'hFFFA};
    lit5  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFC};
    widths = '{1, 3, 16, 9};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_rcv_ready", {31'd0, rcv_ready}, 32'd0);
    chk("rst_trm_valid", {31'd0, trm_valid}, 32'd0);
    chk("rst_trm_data", {16'd0, trm_data}, 32'd0);
    chk("rst_trm_last", {31'd0, trm_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(posedge clk); #1;

    // Full-width values: one per word, one per cycle once primed.
    tb_words = '{16'h8001, 16'h7FFF, 16'h0005};
    build_exp(16, 3);
    check_model("model_bw16", lit16);
    run_layer(16, 3, 0, 0, 100);
    check_got("bw16", lit16);
    chk("bw16_cycles", 32'(cyc <= 4), 32'd1);

    // Nibbles with 5 cycles of consumer backpressure on the first value.
    tb_words = '{16'hA53F};
    build_exp(4, 4);
    check_model("model_bw4", lit4);
    got_q.delete();
    widx = 0;
    start_layer(4, 4);
    rcv_valid = 1'b1;
    rcv_data  = 16'hA53F;
    trm_ready = 1'b0;
    cyc = 0;
    while (widx == 0 && cyc < 20) begin
      @(negedge clk);
      if (rcv_valid && rcv_ready) widx++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_accept", 32'(widx), 32'd1);
    rcv_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, trm_valid}, 32'd1);
      chk("bp_data", {16'd0, trm_data}, 32'h0000FFFF);
      chk("bp_rcv_ready", {31'd0, rcv_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("bp_no_pop", 32'(exp_q.size()), 32'd4);
    pump(0, 0, 50);
    end_checks();
    check_got("bw4", lit4);

    // bw=5: the 4th and 7th values straddle word boundaries.
    tb_words = '{16'hFFFF, 16'h0000, 16'h0007};
    build_exp(5, 7);
    check_model("model_bw5", lit5);
    run_layer(5, 7, 20, 20, 300);
    check_got("bw5", lit5);

    // Long gapped stream at bw=7.
    random_words(7, 1000);
    run_layer(7, 1000, 30, 30, 20000);
    chk("bw7_count", 32'(got_q.size()), 32'd1000);

    foreach (widths[i]) begin
      random_words(widths[i], 37);
      run_layer(widths[i], 37, 25, 25, 2000);
    end

    cfg_case(0, 5, "cfg_bw0");
    cfg_case(17, 5, "cfg_bw17");
    cfg_case(4, 0, "cfg_n0");

    // Reset in the middle of a bw=5 layer after its 2nd word.
    tb_words = '{16'hFFFF, 16'h0000, 16'h0007};
    build_exp(5, 7);
    widx = 0;
    start_layer(5, 7);
    trm_ready = 1'b0;
    rcv_valid = 1'b1;
    rcv_data  = tb_words[0];
    cyc = 0;
    while (widx < 2 && cyc < 20) begin
      @(negedge clk);
      if (rcv_valid && rcv_ready) widx++;
      @(posedge clk); #1;
      rcv_valid = (widx < 2);
      rcv_data  = tb_words[widx];
      cyc++;
    end
    chk("mid_words", 32'(widx), 32'd2);
    rcv_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rcv_ready", {31'd0, rcv_ready}, 32'd0);
    chk("mid_trm_valid", {31'd0, trm_valid}, 32'd0);
    chk("mid_trm_data", {16'd0, trm_data}, 32'd0);
    chk("mid_trm_last", {31'd0, trm_last}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(posedge clk); #1;
    tb_words = '{16'hA53F};
    run_layer(4, 4, 0, 10, 100);
    check_got("post_rst_bw4", lit4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
